// File: rtl/duck_motion_ctrl.sv
// Duck position generator for the hunt screen.
// Produces the sprite top-left corner, facing and FSM state; a hit makes the duck
// fall, wait out a respawn delay, then re-enter at an LFSR-derived X position.
// Optional feature: define DUCK_ESCAPE_EN to let the duck escape off the top of
// the screen after FLIGHT_TICKS ticks of flight without a hit.
module duck_motion_ctrl #(
    parameter int unsigned SCREEN_W      = 1024,
    parameter int unsigned DUCK_WIDTH    = 96,
    parameter int unsigned DUCK_HEIGHT   = 60,
    parameter int unsigned GROUND_Y      = 600,
    parameter int unsigned SPEED_X       = 4,
    parameter int unsigned SPEED_Y       = 3,
    parameter int unsigned FALL_SPEED    = 6,
    parameter int unsigned TICK_DIV      = 1_083_333,
    parameter int unsigned RESPAWN_TICKS = 60,
    parameter int unsigned FLIGHT_TICKS  = 600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hunt_start,
    input  logic        duck_hit,
    output logic [11:0] duck_xpos,
    output logic [11:0] duck_ypos,
    output logic        duck_dir,
    output logic [1:0]  duck_state,
    output logic        duck_visible,
    output logic        duck_escaped
);

    localparam logic [11:0] MaxX      = 12'(SCREEN_W - DUCK_WIDTH);
    localparam logic [11:0] FloorY    = 12'(GROUND_Y - DUCK_HEIGHT);
    localparam logic [11:0] IdleX     = 12'((SCREEN_W - DUCK_WIDTH) / 2);
    localparam logic [11:0] DuckW     = 12'(DUCK_WIDTH);
    localparam logic [11:0] SpeedX    = 12'(SPEED_X);
    localparam logic [11:0] SpeedY    = 12'(SPEED_Y);
    localparam logic [11:0] FallSpeed = 12'(FALL_SPEED);

    localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

    // One counter serves both respawn delay and (optionally) flight duration.
    localparam int unsigned EvtMax = (RESPAWN_TICKS > FLIGHT_TICKS) ? RESPAWN_TICKS
                                                                    : FLIGHT_TICKS;
    localparam int unsigned EvtW   = (EvtMax > 1) ? $clog2(EvtMax + 1) : 1;

    localparam logic [15:0] LfsrSeed = 16'hACE1;
    localparam logic [15:0] LfsrMask = 16'hB400;  // x^16 + x^14 + x^13 + x^11 + 1

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StFlying  = 2'b01,
        StFalling = 2'b10,
        StRespawn = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [11:0]       x_q, x_d;
    logic [11:0]       y_q, y_d;
    logic              dir_q, dir_d;
    logic              up_q, up_d;
    logic              visible_q, visible_d;
    logic              escaped_q, escaped_d;
    logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [EvtW-1:0]   evt_cnt_q, evt_cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;

    logic              tick;
    logic              evt_count_en;
    logic              escape_mode;
    logic              eff_up;
    logic [11:0]       spawn_x;
    logic [11:0]       step_x, step_y;
    logic              step_dir, step_up;

`ifdef DUCK_ESCAPE_EN
    assign evt_count_en = (state_q == StFlying) || (state_q == StRespawn);
    assign escape_mode  = (state_q == StFlying) && (evt_cnt_q >= EvtW'(FLIGHT_TICKS));
`else
    assign evt_count_en = (state_q == StRespawn);
    assign escape_mode  = 1'b0;
`endif

    assign tick   = (state_q != StIdle) && (tick_cnt_q == TickLast);
    // Escaping ducks only climb, so the bottom bounce can never trigger.
    assign eff_up = up_q | escape_mode;

    // Spawn column from the LFSR, folded back inside the playfield when too far right.
    always_comb begin
        spawn_x = {2'b00, lfsr_q[9:0]};
        if (spawn_x > MaxX) begin
            spawn_x = spawn_x - DuckW;
        end
    end

    // One flight step; edge tests come before the add/subtract so nothing wraps.
    always_comb begin
        step_x   = x_q;
        step_dir = dir_q;
        step_y   = y_q;
        step_up  = eff_up;
        if (dir_q) begin
            if (x_q > MaxX - SpeedX) begin
                step_x   = MaxX;
                step_dir = 1'b0;
            end else begin
                step_x = x_q + SpeedX;
            end
        end else begin
            if (x_q < SpeedX) begin
                step_x   = '0;
                step_dir = 1'b1;
            end else begin
                step_x = x_q - SpeedX;
            end
        end
        if (eff_up) begin
            if (y_q < SpeedY) begin
                step_y  = '0;
                step_up = 1'b0;
            end else begin
                step_y = y_q - SpeedY;
            end
        end else begin
            if (y_q > FloorY - SpeedY) begin
                step_y  = FloorY;
                step_up = 1'b1;
            end else begin
                step_y = y_q + SpeedY;
            end
        end
    end

    // Next-state, position and pulse logic; hunt_start low overrides everything.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        up_d      = up_q;
        escaped_d = 1'b0;
        if (!hunt_start) begin
            state_d = StIdle;
            x_d     = IdleX;
            y_d     = FloorY;
            dir_d   = 1'b0;
            up_d    = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StFlying;
                    x_d     = spawn_x;
                    y_d     = FloorY;
                    dir_d   = lfsr_q[10];
                    up_d    = 1'b1;
                end
                StFlying: begin
                    // A hit freezes the position and wins over a same-cycle escape.
                    if (duck_hit) begin
                        state_d = StFalling;
                    end else if (tick) begin
                        x_d   = step_x;
                        dir_d = step_dir;
                        y_d   = step_y;
                        up_d  = step_up;
                        if (escape_mode && (step_y == '0)) begin
                            state_d   = StRespawn;
                            escaped_d = 1'b1;
                        end
                    end
                end
                StFalling: begin
                    if (tick) begin
                        if (y_q >= FloorY - FallSpeed) begin
                            y_d     = FloorY;
                            state_d = StRespawn;
                        end else begin
                            y_d = y_q + FallSpeed;
                        end
                    end
                end
                StRespawn: begin
                    if (tick && (evt_cnt_q == EvtW'(RESPAWN_TICKS - 1))) begin
                        state_d = StFlying;
                        x_d     = spawn_x;
                        y_d     = FloorY;
                        dir_d   = lfsr_q[10];
                        up_d    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        visible_d = (state_d == StFlying) || (state_d == StFalling);
    end

    // Tick divider, per-state tick counter and free-running LFSR.
    always_comb begin
        tick_cnt_d = tick_cnt_q + TickW'(1);
        if ((state_d != state_q) || (state_q == StIdle) || tick) begin
            tick_cnt_d = '0;
        end
        evt_cnt_d = evt_cnt_q;
        if (state_d != state_q) begin
            evt_cnt_d = '0;
        end else if (tick && evt_count_en && (evt_cnt_q != EvtW'(EvtMax))) begin
            evt_cnt_d = evt_cnt_q + EvtW'(1);
        end
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            x_q        <= IdleX;
            y_q        <= FloorY;
            dir_q      <= 1'b0;
            up_q       <= 1'b1;
            visible_q  <= 1'b0;
            escaped_q  <= 1'b0;
            tick_cnt_q <= '0;
            evt_cnt_q  <= '0;
            lfsr_q     <= LfsrSeed;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            up_q       <= up_d;
            visible_q  <= visible_d;
            escaped_q  <= escaped_d;
            tick_cnt_q <= tick_cnt_d;
            evt_cnt_q  <= evt_cnt_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign duck_xpos    = x_q;
    assign duck_ypos    = y_q;
    assign duck_dir     = dir_q;
    assign duck_state   = state_q;
    assign duck_visible = visible_q;
    assign duck_escaped = escaped_q;

endmodule

// File: tb/tb_duck_motion_ctrl.sv
// Directed bench for duck_motion_ctrl with TICK_DIV=4, RESPAWN_TICKS=3, FLIGHT_TICKS=10.
// Honours DUCK_ESCAPE_EN the same way the design does.
`timescale 1ns / 1ps
module tb_duck_motion_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hunt_start;
    logic        duck_hit;
    logic [11:0] duck_xpos;
    logic [11:0] duck_ypos;
    logic        duck_dir;
    logic [1:0]  duck_state;
    logic        duck_visible;
    logic        duck_escaped;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected flight state kept by the bench
    int          ex, ey, ed, eu;
    logic [15:0] m_lfsr;
    logic [15:0] m;
    int          waited;

`ifdef DUCK_ESCAPE_EN
    localparam int HitTicks = 5;
    localparam int HitY     = 525;
`else
    localparam int HitTicks = 80;
    localparam int HitY     = 300;
`endif

    duck_motion_ctrl #(
        .TICK_DIV      (4),
        .RESPAWN_TICKS (3),
        .FLIGHT_TICKS  (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hunt_start   (hunt_start),
        .duck_hit     (duck_hit),
        .duck_xpos    (duck_xpos),
        .duck_ypos    (duck_ypos),
        .duck_dir     (duck_dir),
        .duck_state   (duck_state),
        .duck_visible (duck_visible),
        .duck_escaped (duck_escaped)
    );

    always #5 clk = ~clk;

    // Reference LFSR: seed while in reset, Galois step (mask 0xB400) otherwise
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int spawn_col(input logic [15:0] v);
        int c;
        c = int'(v[9:0]);
        return (c <= 928) ? c : c - 96;
    endfunction

    // One flight tick on the bench's expected state
    task automatic fly_tick();
        if (ed == 1) begin
            if (ex + 4 > 928) begin ex = 928; ed = 0; end
            else ex = ex + 4;
        end else begin
            if (ex - 4 < 0) begin ex = 0; ed = 1; end
            else ex = ex - 4;
        end
        if (eu == 1) begin
            if (ey - 3 < 0) begin ey = 0; eu = 0; end
            else ey = ey - 3;
        end else begin
            if (ey + 3 > 540) begin ey = 540; eu = 1; end
            else ey = ey + 3;
        end
    endtask

    initial begin
        rst_n = 1'b0; hunt_start = 1'b0; duck_hit = 1'b0;
        cyc(3);
        chk("rst_x", duck_xpos, 464);
        chk("rst_y", duck_ypos, 540);
        chk("rst_dir", duck_dir, 0);
        chk("rst_state", duck_state, 0);
        chk("rst_vis", duck_visible, 0);
        chk("rst_esc", duck_escaped, 0);

        // Hit in IDLE is ignored
        rst_n = 1'b1; duck_hit = 1'b1;
        cyc(1);
        duck_hit = 1'b0;
        cyc(2);
        chk("idle_hit_state", duck_state, 0);
        chk("idle_hit_x", duck_xpos, 464);

        // Start and first motion tick
        m = m_lfsr; hunt_start = 1'b1;
        cyc(1);
        ex = spawn_col(m); ed = int'(m[10]); ey = 540; eu = 1;
        chk("start_state", duck_state, 1);
        chk("start_y", duck_ypos, 540);
        chk("start_x", duck_xpos, ex);
        chk("start_dir", duck_dir, ed);
        chk("start_vis", duck_visible, 1);
        cyc(3);
        chk("pretick_y", duck_ypos, 540);
        cyc(1);
        fly_tick();
        chk("tick1_y", duck_ypos, 537);
        chk("tick1_x", duck_xpos, ex);

        // Back to IDLE, then wait for an LFSR value that spawns at x=926 facing right
        hunt_start = 1'b0;
        cyc(1);
        chk("stop_state", duck_state, 0);
        chk("stop_x", duck_xpos, 464);
        chk("stop_y", duck_ypos, 540);
        waited = 0;
        while (!(m_lfsr[10] && (m_lfsr[9:0] == 10'd926 || m_lfsr[9:0] == 10'd1022))
               && waited < 70000) begin
            cyc(1);
            waited++;
        end
        chk("lfsr_wait_bound", waited < 70000, 1);
        m = m_lfsr; hunt_start = 1'b1;
        cyc(1);
        ex = spawn_col(m); ed = int'(m[10]); ey = 540; eu = 1;
        chk("clamp_spawn_x", duck_xpos, 926);
        chk("clamp_spawn_dir", duck_dir, 1);
        cyc(4); fly_tick();
        chk("clamp_x", duck_xpos, 928);
        chk("clamp_dir", duck_dir, 0);
        chk("clamp_y", duck_ypos, 537);
        cyc(4); fly_tick();
        chk("clamp_back_x", duck_xpos, 924);
        chk("clamp_back_y", duck_ypos, 534);

        // Fly on, then hit off-tick with a back-to-back pulse
        for (int i = 2; i < HitTicks; i++) begin
            cyc(4); fly_tick();
        end
        chk("prehit_y", duck_ypos, HitY);
        chk("prehit_x", duck_xpos, ex);
        cyc(1);
        duck_hit = 1'b1;
        cyc(1);
        chk("hit_state", duck_state, 2);
        chk("hit_x", duck_xpos, ex);
        chk("hit_y", duck_ypos, HitY);
        cyc(1);
        duck_hit = 1'b0;
        chk("hit2_state", duck_state, 2);

        // Fall by 6 per tick down to 540
        cyc(3);
        for (int i = 0; i < 100; i++) begin
            ey = (ey + 6 >= 540) ? 540 : ey + 6;
            chk("fall_y", duck_ypos, ey);
            chk("fall_x", duck_xpos, ex);
            if (ey == 540) break;
            chk("fall_state", duck_state, 2);
            cyc(4);
        end
        chk("resp_state", duck_state, 3);
        chk("resp_vis", duck_visible, 0);
        cyc(4);
        chk("resp1_state", duck_state, 3);
        chk("resp1_y", duck_ypos, 540);
        chk("resp1_x", duck_xpos, ex);
        cyc(4);
        chk("resp2_state", duck_state, 3);
        cyc(3);
        m = m_lfsr;
        cyc(1);
        chk("respawn_state", duck_state, 1);
        chk("respawn_y", duck_ypos, 540);
        chk("respawn_x", duck_xpos, spawn_col(m));
        chk("respawn_dir", duck_dir, m[10]);
        chk("respawn_vis", duck_visible, 1);

        // hunt_start low beats a same-cycle hit
        duck_hit = 1'b1; hunt_start = 1'b0;
        cyc(1);
        duck_hit = 1'b0;
        chk("prio_state", duck_state, 0);
        chk("prio_x", duck_xpos, 464);
        chk("prio_y", duck_ypos, 540);
        chk("prio_vis", duck_visible, 0);
        cyc(1);
        chk("prio_state2", duck_state, 0);

        // Escape behaviour
        m = m_lfsr; hunt_start = 1'b1;
        cyc(1);
        ex = spawn_col(m); ed = int'(m[10]); ey = 540; eu = 1;
        chk("esc_start_state", duck_state, 1);
`ifdef DUCK_ESCAPE_EN
        for (int i = 0; i < 10; i++) begin
            cyc(4); fly_tick();
        end
        chk("esc_y10", duck_ypos, 510);
        for (int i = 0; i < 200; i++) begin
            cyc(3);
            chk("esc_low", duck_escaped, 0);
            cyc(1);
            ey = (ey < 3) ? 0 : ey - 3;
            chk("esc_climb_y", duck_ypos, ey);
            if (ey == 0) break;
            chk("esc_low_tick", duck_escaped, 0);
        end
        chk("esc_pulse", duck_escaped, 1);
        chk("esc_state", duck_state, 3);
        cyc(1);
        chk("esc_pulse_end", duck_escaped, 0);
        chk("esc_state2", duck_state, 3);
`else
        for (int i = 0; i < 100; i++) begin
            for (int c = 0; c < 4; c++) begin
                cyc(1);
                chk("noesc_flag", duck_escaped, 0);
            end
            fly_tick();
            chk("noesc_y", duck_ypos, ey);
            chk("noesc_x", duck_xpos, ex);
            chk("noesc_state", duck_state, 1);
        end
        chk("noesc_y100", duck_ypos, 240);
`endif

        // Reset mid-flight
        rst_n = 1'b0;
        cyc(1);
        chk("mid_rst_x", duck_xpos, 464);
        chk("mid_rst_y", duck_ypos, 540);
        chk("mid_rst_state", duck_state, 0);
        chk("mid_rst_dir", duck_dir, 0);
        chk("mid_rst_vis", duck_visible, 0);
        chk("mid_rst_esc", duck_escaped, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
